audio_capture_sched: RTL and testbench
======================================

Name: audio_capture_sched

Overview:
Sequencer for the PDM microphone audio path. It enables the microphone clock, discards the warm-up samples, and captures decimated PCM samples into a single-port sample RAM. It then shares that RAM between two readers: I2S playback and a UART byte dump. It sits in top_pdm, between the button synchronisers, the PDM decimator, the sample RAM, the I2S serializer and the UART transmitter.

Parameters:
DEPTH, 4096, sample RAM depth in samples; must be a power of 2.
AW, 12, RAM address width; equals log2(DEPTH).
SAMPLE_W, 16, PCM sample width; must be 16 for the UART byte split.
WARMUP, 64, number of PCM samples discarded after pdm_en rises; range 0..255.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
btn_capture  in  1  synchronised single-cycle pulse that starts a capture
btn_i2s  in  1  synchronised single-cycle pulse that starts I2S playback
btn_uart  in  1  synchronised single-cycle pulse that starts a UART dump
pdm_en  out  1  enables the m_clk generator and the decimator
pcm_valid  in  1  one-cycle strobe marking a new decimated sample
pcm_data  in  SAMPLE_W  decimated sample, valid with pcm_valid
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  SAMPLE_W  RAM write data
ram_rdata  in  SAMPLE_W  RAM read data, 1-cycle latency after ram_addr
i2s_req  in  1  pulse from the I2S serializer requesting the next sample; pulses are at least 4 cycles apart
i2s_sample  out  SAMPLE_W  sample for the I2S serializer
i2s_sample_valid  out  1  one-cycle strobe marking i2s_sample as updated
uart_valid  out  1  UART byte valid
uart_data  out  8  UART byte
uart_ready  in  1  UART transmitter accepts the byte
led  out  4  status: [0] capturing, [1] playing, [2] dumping, [3] buffer holds data

Behaviour:
- Reset (reset_n=0 at a clk edge) applies in any state, including mid-operation. It forces state IDLE and sets every output to 0. It clears wr_addr, rd_addr, cap_len (AW+1 bits), warm_cnt and the byte phase. RAM contents are don't-care afterwards.
- FSM states: IDLE, WARMUP, CAPTURE, PLAY, DUMP_RD, DUMP_HI, DUMP_LO.
- IDLE:
  - Button priority when pulses coincide: capture > i2s > uart.
  - btn_capture: pdm_en<=1, warm_cnt<=0, wr_addr<=0, cap_len<=0, next state WARMUP (CAPTURE if WARMUP=0).
  - btn_i2s or btn_uart with cap_len=0: ignored, stay IDLE.
  - Otherwise set rd_addr<=0 and go to PLAY or DUMP_RD.
- Buttons pressed in any non-IDLE state are ignored.
- WARMUP: each pcm_valid increments warm_cnt. The strobe on which warm_cnt reaches WARMUP enters CAPTURE; that sample is not stored.
- CAPTURE:
  - On pcm_valid in the same cycle: ram_we=1, ram_addr=wr_addr, ram_wdata=pcm_data; wr_addr and cap_len increment.
  - When cap_len reaches DEPTH, pdm_en<=0 and go to IDLE the next cycle. wr_addr wraps to 0 and nothing is overwritten.
- PLAY:
  - On i2s_req, drive ram_addr=rd_addr in that cycle.
  - One cycle later: i2s_sample<=ram_rdata and i2s_sample_valid=1 for exactly one cycle.
  - rd_addr increments. After the sample at rd_addr=cap_len-1 is delivered, go to IDLE. i2s_sample holds its last value.
- UART dump:
  - DUMP_RD: drive ram_addr=rd_addr for one cycle, capture ram_rdata on the next cycle, then go to DUMP_HI.
  - DUMP_HI: uart_valid=1, uart_data=sample[15:8]. Data is held stable until a cycle with uart_valid&uart_ready; then go to DUMP_LO.
  - DUMP_LO: same handshake with sample[7:0].
  - On the LO handshake, rd_addr increments. If it was cap_len-1, go to IDLE; otherwise go to DUMP_RD.
  - uart_valid is deasserted in the cycle after a handshake.
- RAM access:
  - ram_we is asserted only in CAPTURE.
  - ram_addr is 0 when the RAM is not being accessed.
  - Reads and writes are never concurrent by construction.
- LEDs: led[0] = state is WARMUP or CAPTURE; led[1] = PLAY; led[2] = any DUMP_* state; led[3] = cap_len != 0.

Optional Feature:
AUTO_PLAY_EN.
- Defined: when a capture completes, the FSM goes directly from CAPTURE to PLAY with rd_addr=0, without passing through IDLE. pdm_en still drops on the transition.
- Undefined: a completed capture returns to IDLE, and playback requires btn_i2s.

Test Plan:
1. Capture. Setup: DEPTH=16, WARMUP=4, feed pcm_data=0x1000+n on 24 strobes after btn_capture. Required: first 4 samples discarded; RAM[0..15]=0x1004..0x1013; pdm_en drops after the 16th write; led=4'b1000.
2. I2S playback. Setup: after test 1, pulse btn_i2s, then 16 i2s_req pulses spaced 8 cycles apart. Required: each i2s_sample_valid comes 1 cycle after its request, values 0x1004..0x1013; FSM returns to IDLE; a 17th i2s_req produces no valid strobe.
3. UART dump with back-pressure. Setup: btn_uart; uart_ready toggles 1/0 every 3 cycles. Required: 32 bytes 0x10,0x04,0x10,0x05,…,0x10,0x13; no byte duplicated or dropped; uart_data stable while valid&!ready.
4. Simultaneous buttons and empty buffer. Setup: btn_i2s alone right after reset; then btn_capture and btn_uart in the same cycle. Required: the first press is ignored (cap_len=0); the second starts WARMUP and the UART press is dropped.
5. Reset mid-operation. Setup: assert reset_n=0 during CAPTURE at cap_len=7. Required: all outputs 0 the next cycle; led=0; a following btn_i2s is ignored.
6. Optional feature. Setup: AUTO_PLAY_EN defined, repeat test 1. Required: state enters PLAY with no button press; i2s_req yields 0x1004 first.

Source files
------------

// File: rtl/audio_capture_sched.sv
// PDM capture sequencer: warm-up discard, capture to RAM, I2S / UART readout.
// Optional AUTO_PLAY_EN: a completed capture goes straight into playback.
module audio_capture_sched #(
  parameter int DEPTH    = 4096,
  parameter int AW       = 12,
  parameter int SAMPLE_W = 16,
  parameter int WARMUP   = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_capture,
  input  logic                btn_i2s,
  input  logic                btn_uart,
  output logic                pdm_en,
  input  logic                pcm_valid,
  input  logic [SAMPLE_W-1:0] pcm_data,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [SAMPLE_W-1:0] ram_wdata,
  input  logic [SAMPLE_W-1:0] ram_rdata,
  input  logic                i2s_req,
  output logic [SAMPLE_W-1:0] i2s_sample,
  output logic                i2s_sample_valid,
  output logic                uart_valid,
  output logic [7:0]          uart_data,
  input  logic                uart_ready,
  output logic [3:0]          led
);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_CAPTURE, S_PLAY,
    S_DUMP_RD, S_DUMP_HI, S_DUMP_LO
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [7:0]  WU   = 8'(WARMUP);

  state_t        state;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   cap_len;
  logic [7:0]    warm_cnt;
  logic          rd_pend;
  logic          dump_ph;
  logic [7:0]    lo_byte;
  logic          rd_last;

  assign rd_last = ({1'b0, rd_addr} + 1'b1) == cap_len;

  // RAM port: writes in capture, reads on a play request or dump fetch
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == S_CAPTURE && pcm_valid) begin
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = pcm_data;
    end else if (state == S_PLAY && i2s_req && !rd_pend) begin
      ram_addr = rd_addr;
    end else if (state == S_DUMP_RD && !dump_ph) begin
      ram_addr = rd_addr;
    end
  end

  // Status LEDs follow the registered state and buffer length
  assign led = {
    cap_len != '0,
    (state == S_DUMP_RD) || (state == S_DUMP_HI) || (state == S_DUMP_LO),
    state == S_PLAY,
    (state == S_WARMUP) || (state == S_CAPTURE)
  };

  // Main sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      wr_addr          <= '0;
      rd_addr          <= '0;
      cap_len          <= '0;
      warm_cnt         <= '0;
      rd_pend          <= 1'b0;
      dump_ph          <= 1'b0;
      lo_byte          <= '0;
      pdm_en           <= 1'b0;
      i2s_sample       <= '0;
      i2s_sample_valid <= 1'b0;
      uart_valid       <= 1'b0;
      uart_data        <= '0;
    end else begin
      i2s_sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (btn_capture) begin
            pdm_en   <= 1'b1;
            warm_cnt <= '0;
            wr_addr  <= '0;
            cap_len  <= '0;
            state    <= (WARMUP == 0) ? S_CAPTURE : S_WARMUP;
          end else if (btn_i2s && cap_len != '0) begin
            rd_addr <= '0;
            rd_pend <= 1'b0;
            state   <= S_PLAY;
          end else if (btn_uart && cap_len != '0) begin
            rd_addr <= '0;
            dump_ph <= 1'b0;
            state   <= S_DUMP_RD;
          end
        end
        S_WARMUP: begin
          if (pcm_valid) begin
            warm_cnt <= warm_cnt + 8'd1;
            if (warm_cnt + 8'd1 == WU)
              state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (pcm_valid) begin
            wr_addr <= wr_addr + 1'b1;
            cap_len <= cap_len + 1'b1;
            if (cap_len + 1'b1 == FULL) begin
              pdm_en <= 1'b0;
`ifdef AUTO_PLAY_EN
              rd_addr <= '0;
              rd_pend <= 1'b0;
              state   <= S_PLAY;
`else
              state <= S_IDLE;
`endif
            end
          end
        end
        S_PLAY: begin
          if (rd_pend) begin
            rd_pend          <= 1'b0;
            i2s_sample       <= ram_rdata;
            i2s_sample_valid <= 1'b1;
            rd_addr          <= rd_addr + 1'b1;
            if (rd_last)
              state <= S_IDLE;
          end else if (i2s_req) begin
            rd_pend <= 1'b1;
          end
        end
        S_DUMP_RD: begin
          if (!dump_ph) begin
            dump_ph <= 1'b1;
          end else begin
            dump_ph    <= 1'b0;
            lo_byte    <= ram_rdata[7:0];
            uart_data  <= ram_rdata[15:8];
            uart_valid <= 1'b1;
            state      <= S_DUMP_HI;
          end
        end
        S_DUMP_HI: begin
          if (uart_valid && uart_ready) begin
            uart_valid <= 1'b0;
            state      <= S_DUMP_LO;
          end
        end
        S_DUMP_LO: begin
          if (!uart_valid) begin
            uart_valid <= 1'b1;
            uart_data  <= lo_byte;
          end else if (uart_ready) begin
            uart_valid <= 1'b0;
            rd_addr    <= rd_addr + 1'b1;
            state      <= rd_last ? S_IDLE : S_DUMP_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_capture_sched.sv
// Directed bench for audio_capture_sched (DEPTH=16, WARMUP=4).
// Builds with or without AUTO_PLAY_EN.
module tb_audio_capture_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_capture = 1'b0;
  logic        btn_i2s = 1'b0;
  logic        btn_uart = 1'b0;
  logic        pdm_en;
  logic        pcm_valid = 1'b0;
  logic [15:0] pcm_data = '0;
  logic        ram_we;
  logic [3:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic        i2s_req = 1'b0;
  logic [15:0] i2s_sample;
  logic        i2s_sample_valid;
  logic        uart_valid;
  logic [7:0]  uart_data;
  logic        uart_ready = 1'b0;
  logic [3:0]  led;

  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_capture_sched #(
    .DEPTH(16), .AW(4), .SAMPLE_W(16), .WARMUP(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_capture(btn_capture), .btn_i2s(btn_i2s),
    .btn_uart(btn_uart), .pdm_en(pdm_en),
    .pcm_valid(pcm_valid), .pcm_data(pcm_data),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .i2s_req(i2s_req), .i2s_sample(i2s_sample),
    .i2s_sample_valid(i2s_sample_valid),
    .uart_valid(uart_valid), .uart_data(uart_data),
    .uart_ready(uart_ready), .led(led)
  );

  // Sample RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({pdm_en, ram_we, ram_addr, ram_wdata, i2s_sample,
         i2s_sample_valid, uart_valid, uart_data, led} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: led=%b pdm_en=%b uart_valid=%b expected all 0",
               led, pdm_en, uart_valid);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    logic exp_we;
    btn_capture = 1'b1;
    tick();
    btn_capture = 1'b0;
    checks++;
    if (pdm_en !== 1'b1 || led !== 4'b0001) begin
      errors++;
      $display("FAIL cap_start: pdm_en=%b led=%b expected 1 0001", pdm_en, led);
    end
    for (int n = 0; n < 24; n++) begin
      pcm_valid = 1'b1;
      pcm_data  = 16'(16'h1000 + n);
      #1;
      exp_we = (n >= 4 && n <= 19);
      checks++;
      if (ram_we !== exp_we) begin
        errors++;
        $display("FAIL cap_we[%0d]: got %b expected %b", n, ram_we, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (ram_addr !== 4'(n - 4) || ram_wdata !== 16'(16'h1000 + n)) begin
          errors++;
          $display("FAIL cap_wr[%0d]: addr=%0d data=%h expected %0d %h",
                   n, ram_addr, ram_wdata, n - 4, 16'(16'h1000 + n));
        end
      end
      @(posedge clk);
      #1;
      pcm_valid = 1'b0;
      checks++;
      if (pdm_en !== (n < 19)) begin
        errors++;
        $display("FAIL cap_pdm_en[%0d]: got %b expected %b", n, pdm_en, n < 19);
      end
      tick();
      tick();
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (mem[a] !== 16'(16'h1004 + a)) begin
        errors++;
        $display("FAIL cap_ram[%0d]: got %h expected %h", a, mem[a], 16'(16'h1004 + a));
      end
    end
    checks++;
`ifdef AUTO_PLAY_EN
    if (led !== 4'b1010) begin
      errors++;
      $display("FAIL cap_done_led: got %b expected 1010", led);
    end
`else
    if (led !== 4'b1000) begin
      errors++;
      $display("FAIL cap_done_led: got %b expected 1000", led);
    end
`endif
  endtask

  task automatic test_i2s(input bit press);
    if (press) begin
      btn_i2s = 1'b1;
      tick();
      btn_i2s = 1'b0;
      checks++;
      if (led !== 4'b1010) begin
        errors++;
        $display("FAIL i2s_start_led: got %b expected 1010", led);
      end
    end
    for (int k = 0; k < 17; k++) begin
      i2s_req = 1'b1;
      tick();
      i2s_req = 1'b0;
      checks++;
      if (i2s_sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL i2s_early[%0d]: valid=%b expected 0", k, i2s_sample_valid);
      end
      tick();
      checks++;
      if (k < 16) begin
        if (i2s_sample_valid !== 1'b1 || i2s_sample !== 16'(16'h1004 + k)) begin
          errors++;
          $display("FAIL i2s_sample[%0d]: valid=%b data=%h expected 1 %h",
                   k, i2s_sample_valid, i2s_sample, 16'(16'h1004 + k));
        end
      end else begin
        if (i2s_sample_valid !== 1'b0 || i2s_sample !== 16'h1013) begin
          errors++;
          $display("FAIL i2s_extra: valid=%b data=%h expected 0 1013",
                   i2s_sample_valid, i2s_sample);
        end
      end
      tick();
      checks++;
      if (i2s_sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL i2s_one_cycle[%0d]: valid=%b expected 0", k, i2s_sample_valid);
      end
      repeat (5) tick();
    end
    checks++;
    if (led !== 4'b1000) begin
      errors++;
      $display("FAIL i2s_done_led: got %b expected 1000", led);
    end
  endtask

  task automatic test_uart();
    int got = 0;
    bit hold_pend = 1'b0;
    logic [7:0] hold = '0;
    logic [7:0] exp_b;
    btn_uart = 1'b1;
    tick();
    btn_uart = 1'b0;
    checks++;
    if (led !== 4'b1100) begin
      errors++;
      $display("FAIL uart_start_led: got %b expected 1100", led);
    end
    for (int c = 0; c < 2000 && got < 32; c++) begin
      uart_ready = ((c / 3) % 2) == 0;
      #1;
      if (hold_pend) begin
        checks++;
        if (uart_valid !== 1'b1 || uart_data !== hold) begin
          errors++;
          $display("FAIL uart_stable: valid=%b data=%h expected 1 %h",
                   uart_valid, uart_data, hold);
        end
      end
      hold_pend = 1'b0;
      if (uart_valid === 1'b1) begin
        if (uart_ready) begin
          exp_b = (got % 2 == 0) ? 8'h10 : 8'(8'h04 + got / 2);
          checks++;
          if (uart_data !== exp_b) begin
            errors++;
            $display("FAIL uart_byte[%0d]: got %h expected %h", got, uart_data, exp_b);
          end
          got++;
        end else begin
          hold_pend = 1'b1;
          hold = uart_data;
        end
      end
      tick();
    end
    checks++;
    if (got != 32) begin
      errors++;
      $display("FAIL uart_count: got %0d bytes expected 32", got);
    end
    uart_ready = 1'b1;
    repeat (6) begin
      checks++;
      if (uart_valid !== 1'b0) begin
        errors++;
        $display("FAIL uart_extra: valid=%b expected 0", uart_valid);
      end
      tick();
    end
    uart_ready = 1'b0;
    checks++;
    if (led !== 4'b1000) begin
      errors++;
      $display("FAIL uart_done_led: got %b expected 1000", led);
    end
  endtask

  task automatic test_buttons();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    btn_i2s = 1'b1;
    tick();
    btn_i2s = 1'b0;
    checks++;
    if (led !== 4'b0000) begin
      errors++;
      $display("FAIL empty_i2s_led: got %b expected 0000", led);
    end
    i2s_req = 1'b1;
    tick();
    i2s_req = 1'b0;
    tick();
    checks++;
    if (i2s_sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_i2s_valid: got %b expected 0", i2s_sample_valid);
    end
    btn_capture = 1'b1;
    btn_uart = 1'b1;
    tick();
    btn_capture = 1'b0;
    btn_uart = 1'b0;
    checks++;
    if (led !== 4'b0001 || pdm_en !== 1'b1) begin
      errors++;
      $display("FAIL both_btn: led=%b pdm_en=%b expected 0001 1", led, pdm_en);
    end
    repeat (3) tick();
    checks++;
    if (led !== 4'b0001 || uart_valid !== 1'b0) begin
      errors++;
      $display("FAIL both_btn_hold: led=%b uart_valid=%b expected 0001 0",
               led, uart_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 11; n++) begin
      pcm_valid = 1'b1;
      pcm_data  = 16'(16'h2000 + n);
      tick();
      pcm_valid = 1'b0;
      tick();
    end
    checks++;
    if (led !== 4'b1001) begin
      errors++;
      $display("FAIL mid_cap_led: got %b expected 1001", led);
    end
    pcm_valid = 1'b1;
    pcm_data  = 16'hBEEF;
    reset_n = 1'b0;
    tick();
    checks++;
    if ({pdm_en, ram_we, ram_addr, ram_wdata, i2s_sample,
         i2s_sample_valid, uart_valid, uart_data, led} !== '0) begin
      errors++;
      $display("FAIL mid_reset_out: led=%b pdm_en=%b ram_we=%b expected all 0",
               led, pdm_en, ram_we);
    end
    pcm_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    btn_i2s = 1'b1;
    tick();
    btn_i2s = 1'b0;
    i2s_req = 1'b1;
    tick();
    i2s_req = 1'b0;
    tick();
    checks++;
    if (led !== 4'b0000 || i2s_sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_i2s: led=%b valid=%b expected 0000 0",
               led, i2s_sample_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_capture();
`ifdef AUTO_PLAY_EN
    test_i2s(1'b0);
`else
    test_i2s(1'b1);
`endif
    test_uart();
    test_buttons();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
